// File: rtl/dda_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dda_seq_ctrl
//
// Run sequencer for the posit Van der Pol DDA core. A run loads the initial
// conditions into the integrators, steps the core for a programmed number of
// Euler steps, and decimates the x/y trajectory into a small
// first-word-fall-through sample FIFO. When the FIFO is full, the core is
// frozen so that no sample is ever dropped.
//
// Optional feature macro: DDA_SEQ_NAR_CHECK_EN
//   When this macro is defined, a step whose x_in or y_in is NaR does not
//   execute. The run then sets err, drains and completes normally. When the
//   macro is undefined, err is tied low and NaR is treated as an ordinary
//   value.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a run (IDLE only) / kill the run immediately
//   n_steps, decim      steps to run and decimation factor (0 acts as 1);
//                       both are latched on an accepted start
//   x_in, y_in          current DDA state
//   dda_rst_n, dda_ce   DDA load strobe (low = load ICs) and step enable
//   busy, done, err     run status; done is a one-cycle pulse
//   smp_valid/ready     sample FIFO handshake
//   smp_x, smp_y        sampled state
//   smp_idx             step number of the sample
// ---------------------------------------------------------------------------
module dda_seq_ctrl #(
    parameter int N          = 16,
    parameter int STEP_W     = 16,
    parameter int DECIM_W    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [STEP_W-1:0]  n_steps,
    input  logic [DECIM_W-1:0] decim,
    input  logic [N-1:0]       x_in,
    input  logic [N-1:0]       y_in,
    output logic               dda_rst_n,
    output logic               dda_ce,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               smp_valid,
    input  logic               smp_ready,
    output logic [N-1:0]       smp_x,
    output logic [N-1:0]       smp_y,
    output logic [STEP_W-1:0]  smp_idx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 2 * N + STEP_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state;
    logic [STEP_W-1:0]  n_lat;
    logic [STEP_W-1:0]  step_cnt;
    logic [DECIM_W-1:0] decim_lat;
    logic [DECIM_W-1:0] dec_cnt;
    logic               done_q;

    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;

    logic               fifo_full;
    logic               fifo_empty;
    logic               nar;
    logic               step_go;
    logic               push;
    logic               pop;
    logic               last_step;

`ifdef DDA_SEQ_NAR_CHECK_EN
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};
    logic err_q;

    assign nar = (x_in == NAR) || (y_in == NAR);
    assign err = err_q;
`else
    assign nar = 1'b0;
    assign err = 1'b0;
`endif

    // FIFO status comes only from the registered occupancy. Because of this,
    // the stall decision never sees smp_ready combinationally.
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // A step executes in RUN when there is room for a possible sample and
    // the state is not NaR. A full FIFO freezes the whole step.
    assign step_go   = (state == RUN) && !fifo_full && !nar && !abort;
    assign push      = step_go && (dec_cnt == '0);
    assign pop       = !fifo_empty && smp_ready;
    assign last_step = (step_cnt == n_lat - STEP_W'(1));

    // During LOAD, the ICs are written. In RUN, the core advances whenever
    // the sequencer will accept the step. In DRAIN, the core state is held.
    assign dda_rst_n = (state == RUN) || (state == DRAIN);
    assign dda_ce    = (state == LOAD) ||
                       ((state == RUN) && !fifo_full && !nar);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign smp_valid = !fifo_empty;
    assign {smp_x, smp_y, smp_idx} = mem[rd_ptr];

    // Run state machine together with its step and decimation counters.
    // abort takes priority over everything except rst. The done pulse is
    // registered, so it lines up with busy falling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            n_lat     <= '0;
            decim_lat <= '0;
            step_cnt  <= '0;
            dec_cnt   <= '0;
            done_q    <= 1'b0;
`ifdef DDA_SEQ_NAR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            n_lat     <= n_steps;
                            decim_lat <= (decim == '0) ? DECIM_W'(1) : decim;
                            step_cnt  <= '0;
                            dec_cnt   <= '0;
`ifdef DDA_SEQ_NAR_CHECK_EN
                            err_q     <= 1'b0;
`endif
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= (n_lat == '0) ? DRAIN : RUN;
                    end
                    RUN: begin
                        if (step_go) begin
                            step_cnt <= step_cnt + STEP_W'(1);
                            dec_cnt  <= (dec_cnt == decim_lat - DECIM_W'(1)) ?
                                        '0 : dec_cnt + DECIM_W'(1);
                            if (last_step) begin
                                state <= DRAIN;
                            end
                        end
`ifdef DDA_SEQ_NAR_CHECK_EN
                        else if (!fifo_full && nar) begin
                            err_q <= 1'b1;
                            state <= DRAIN;
                        end
`endif
                    end
                    DRAIN: begin
                        if (fifo_empty) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Sample FIFO (first-word-fall-through). Each entry is {x, y, step index}.
    // The FIFO is flushed on abort. A push and a pop in the same cycle leave
    // the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {x_in, y_in, step_cnt};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dda_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dda_seq_ctrl
//
// Scoreboard bench for dda_seq_ctrl. A toy DDA core reacts to the
// dda_rst_n and dda_ce outputs:
//   - on load, it sets x = icx and y = icy;
//   - on each step, it adds 1 to x and 3 to y.
// With this core, the sample taken at step i must be {icx+i, icy+3i, i}.
//
// Stimulus tasks push the expected samples into a queue. A monitor pops the
// queue and compares an entry on every accepted FIFO transfer.
// ---------------------------------------------------------------------------
module tb_dda_seq_ctrl;

    localparam int N       = 16;
    localparam int STEP_W  = 16;
    localparam int DECIM_W = 8;

    typedef struct packed {
        logic [N-1:0]      x;
        logic [N-1:0]      y;
        logic [STEP_W-1:0] idx;
    } sample_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [STEP_W-1:0]  n_steps;
    logic [DECIM_W-1:0] decim;
    logic [N-1:0]       x_in;
    logic [N-1:0]       y_in;
    logic               dda_rst_n;
    logic               dda_ce;
    logic               busy;
    logic               done;
    logic               err;
    logic               smp_valid;
    logic               smp_ready;
    logic [N-1:0]       smp_x;
    logic [N-1:0]       smp_y;
    logic [STEP_W-1:0]  smp_idx;

    logic [N-1:0]       icx;
    logic [N-1:0]       icy;
    logic [N-1:0]       x_model;
    logic [N-1:0]       y_model;
    logic               nar_inj;

    sample_t            sb_q[$];
    int                 compared   = 0;
    int                 mismatched = 0;
    int                 done_cnt   = 0;
    int                 step_cycles = 0;
    int                 snap;

    dda_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .n_steps   (n_steps),
        .decim     (decim),
        .x_in      (x_in),
        .y_in      (y_in),
        .dda_rst_n (dda_rst_n),
        .dda_ce    (dda_ce),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_x     (smp_x),
        .smp_y     (smp_y),
        .smp_idx   (smp_idx)
    );

    always #5 clk = ~clk;

    // Toy DDA core: loads the ICs while dda_rst_n is low and advances one
    // step per enabled cycle. nar_inj forces x to NaR at step 6.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            x_model <= '0;
            y_model <= '0;
        end else if (dda_ce && !dda_rst_n) begin
            x_model <= icx;
            y_model <= icy;
        end else if (dda_ce && dda_rst_n) begin
            x_model <= x_model + 16'd1;
            y_model <= y_model + 16'd3;
        end
    end

    assign x_in = (nar_inj && (x_model == icx + 16'd6)) ? 16'h8000 : x_model;
    assign y_in = y_model;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: count done pulses and step cycles, and score every sample
    // that the consumer accepts.
    always @(negedge clk) begin
        sample_t e;
        if (done) done_cnt++;
        if (dda_ce && dda_rst_n) step_cycles++;
        if (!rst && smp_valid && smp_ready) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_sample: got idx %0d, expected none", smp_idx);
            end else begin
                e = sb_q.pop_front();
                checkOutput("sample", {16'h0, smp_x, smp_y, smp_idx}, {16'h0, e});
            end
        end
    end

    // Queues the expected samples, then issues a one-cycle start. On return,
    // the bench sits 1 ns into the LOAD cycle.
    task automatic applyStimulus(input int n, input int d, input logic [N-1:0] ix,
                                 input logic [N-1:0] iy, input bit narRun);
        int dd;
        sample_t s;
        dd  = (d == 0) ? 1 : d;
        icx = ix;
        icy = iy;
        for (int i = 0; i < n; i += dd) begin
`ifdef DDA_SEQ_NAR_CHECK_EN
            if (narRun && i >= 6) break;
`endif
            s.x   = (narRun && i == 6) ? 16'h8000 : ix + N'(i);
            s.y   = iy + N'(3 * i);
            s.idx = STEP_W'(i);
            sb_q.push_back(s);
        end
        @(posedge clk); #1;
        start   = 1'b1;
        n_steps = STEP_W'(n);
        decim   = DECIM_W'(d);
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic waitDone(input int maxCycles, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < maxCycles; k++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(name, {63'h0, seen}, 64'h1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; smp_ready = 1'b1;
        n_steps = '0; decim = '0; icx = '0; icy = '0; nar_inj = 1'b0;
        #1;
        checkOutput("rst_busy", {63'h0, busy}, 64'h0);
        checkOutput("rst_ctrl", {62'h0, dda_rst_n, dda_ce}, 64'h0);
        checkOutput("rst_flags", {61'h0, done, err, smp_valid}, 64'h0);
        checkOutput("rst_data", {16'h0, smp_x, smp_y, smp_idx}, 64'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // 8 steps, decim 1: LOAD/RUN timeline, 8 samples, 8 step cycles.
        step_cycles = 0;
        snap = done_cnt;
        applyStimulus(8, 1, 16'h0100, 16'h0200, 1'b0);
        checkOutput("t1_load", {61'h0, busy, dda_rst_n, dda_ce}, 64'h5);
        @(posedge clk); #1;
        checkOutput("t1_run_novalid", {62'h0, dda_rst_n, smp_valid}, 64'h2);
        @(posedge clk); #1;
        checkOutput("t1_first_valid", {63'h0, smp_valid}, 64'h1);
        waitDone(40, "t1_done");
        checkOutput("t1_busy_at_done", {63'h0, busy}, 64'h0);
        repeat (2) @(posedge clk); #1;
        checkOutput("t1_done_pulses", 64'(done_cnt - snap), 64'h1);
        checkOutput("t1_step_cycles", 64'(step_cycles), 64'd8);
        checkOutput("t1_sb_empty", 64'(sb_q.size()), 64'h0);

        // Decimation by 4 over 10 steps, then decim 0 (treated as 1) over 3 steps.
        applyStimulus(10, 4, 16'h1000, 16'h2000, 1'b0);
        waitDone(60, "t2_done");
        checkOutput("t2_sb_empty", 64'(sb_q.size()), 64'h0);
        applyStimulus(3, 0, 16'h0010, 16'h0020, 1'b0);
        waitDone(40, "t2b_done");
        checkOutput("t2b_sb_empty", 64'(sb_q.size()), 64'h0);

        // Backpressure: the FIFO fills after 4 pushes, and the core freezes.
        smp_ready = 1'b0;
        applyStimulus(20, 1, 16'h0300, 16'h0400, 1'b0);
        repeat (30) @(posedge clk); #1;
        checkOutput("t3_stalled", {60'h0, busy, dda_rst_n, dda_ce, smp_valid}, 64'hD);
        checkOutput("t3_frozen_x", {48'h0, x_in}, 64'h0304);
        smp_ready = 1'b1;
        waitDone(100, "t3_done");
        checkOutput("t3_sb_empty", 64'(sb_q.size()), 64'h0);

        // n_steps = 0: LOAD, DRAIN, and done in the third cycle after start.
        applyStimulus(0, 1, 16'h0500, 16'h0600, 1'b0);
        checkOutput("t4_load", {62'h0, busy, dda_rst_n}, 64'h2);
        @(posedge clk); #1;
        checkOutput("t4_drain", {61'h0, done, dda_rst_n, dda_ce}, 64'h2);
        @(posedge clk); #1;
        checkOutput("t4_done", {62'h0, done, busy}, 64'h2);

        // Abort in the middle of a 100-step run.
        applyStimulus(100, 1, 16'h0700, 16'h0800, 1'b0);
        repeat (3) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("t5_aborted", {61'h0, busy, smp_valid, dda_rst_n}, 64'h0);
        sb_q.delete();
        snap = done_cnt;
        repeat (5) @(posedge clk); #1;
        checkOutput("t5_no_done", 64'(done_cnt - snap), 64'h0);
        // start and abort together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1; n_steps = 16'd5; decim = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checkOutput("t5_abort_wins", {63'h0, busy}, 64'h0);
        applyStimulus(5, 1, 16'h0900, 16'h0A00, 1'b0);
        waitDone(40, "t5_rerun_done");
        checkOutput("t5_sb_empty", 64'(sb_q.size()), 64'h0);

        // NaR at step 6.
        nar_inj = 1'b1;
        applyStimulus(10, 1, 16'h0B00, 16'h0C00, 1'b1);
        waitDone(60, "t6_done");
`ifdef DDA_SEQ_NAR_CHECK_EN
        checkOutput("t6_err", {63'h0, err}, 64'h1);
`else
        checkOutput("t6_err", {63'h0, err}, 64'h0);
`endif
        checkOutput("t6_sb_empty", 64'(sb_q.size()), 64'h0);
        nar_inj = 1'b0;
        applyStimulus(2, 1, 16'h0D00, 16'h0E00, 1'b0);
        checkOutput("t6_err_cleared", {63'h0, err}, 64'h0);
        waitDone(40, "t6b_done");
        checkOutput("t6b_sb_empty", 64'(sb_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
